// File: rtl/usart_pkg.sv
// usart_pkg: shared types, character-size / parity-mode encodings and
// helper functions for the USART transmit path.
package usart_pkg;

  // Widest character the transmitter can send (9-bit mode uses TXB8).
  localparam int CHAR_MAX_W = 9;

  // Transmitter sequencing states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PEND   = 3'd1,
    ST_START  = 3'd2,
    ST_DATA   = 3'd3,
    ST_PARITY = 3'd4,
    ST_STOP1  = 3'd5,
    ST_STOP2  = 3'd6
  } tx_state_t;

  // UCSZ character-size encodings.
  localparam logic [2:0] UCSZ_5 = 3'b000;
  localparam logic [2:0] UCSZ_6 = 3'b001;
  localparam logic [2:0] UCSZ_7 = 3'b010;
  localparam logic [2:0] UCSZ_8 = 3'b011;
  localparam logic [2:0] UCSZ_9 = 3'b111;

  // UPM parity-mode encodings; bit 1 enables parity, bit 0 selects odd.
  localparam logic [1:0] UPM_NONE = 2'b00;
  localparam logic [1:0] UPM_RSVD = 2'b01;
  localparam logic [1:0] UPM_EVEN = 2'b10;
  localparam logic [1:0] UPM_ODD  = 2'b11;

  // Number of data bits for a UCSZ code; reserved codes fall back to 8.
  function automatic logic [3:0] char_bits(input logic [2:0] ucsz);
    logic [3:0] n;
    case (ucsz)
      UCSZ_5:  n = 4'd5;
      UCSZ_6:  n = 4'd6;
      UCSZ_7:  n = 4'd7;
      UCSZ_8:  n = 4'd8;
      UCSZ_9:  n = 4'd9;
      default: n = 4'd8;
    endcase
    return n;
  endfunction

  // Parity over the low nbits of data; odd=1 inverts the even result.
  function automatic logic parity_bit(input logic [CHAR_MAX_W-1:0] data,
                                      input logic [3:0]            nbits,
                                      input logic                  odd);
    logic p;
    p = odd;
    for (int i = 0; i < CHAR_MAX_W; i++) begin
      if (i < int'(nbits)) p = p ^ data[i];
    end
    return p;
  endfunction

endpackage

// File: rtl/usart_tx_shifter.sv
// usart_tx_shifter: USART transmit serializer. Pops one character per frame
// from the TX FIFO and shifts out start, 5-9 data bits (LSB first), optional
// parity and 1-2 stop bits, one bit per baud_tick. txc_set pulses when the
// line returns to idle.
// Optional build macro USART_TX_BREAK_EN adds a tx_break input that holds
// the idle line low and blocks new frames while asserted.
module usart_tx_shifter
  import usart_pkg::*;
#(
  parameter int DATA_W = 9
) (
  input  logic              cp2,
  input  logic              ireset,
  input  logic              baud_tick,
  input  logic              txen,
  input  logic [2:0]        ucsz,
  input  logic [1:0]        upm,
  input  logic              usbs,
  input  logic [DATA_W-1:0] fifo_dout,
  input  logic              fifo_empty,
`ifdef USART_TX_BREAK_EN
  input  logic              tx_break,
`endif
  output logic              fifo_re,
  output logic              txd,
  output logic              busy,
  output logic              txc_set
);

  tx_state_t             state;
  logic [CHAR_MAX_W-1:0] shreg;     // remaining data bits, next bit at [0]
  logic [3:0]            cnt;       // data bits already placed on the line
  logic [3:0]            nbits;     // frame-constant character size
  logic                  par_en;    // frame-constant parity enable
  logic                  par_val;   // parity bit computed when loaded
  logic                  two_stop;  // frame-constant stop-bit count select

  logic [CHAR_MAX_W-1:0] char_word;
  logic                  brk_req;
  logic                  brk_hold;
  logic                  final_stop;
  logic                  load;

  assign char_word = CHAR_MAX_W'(fifo_dout);

`ifdef USART_TX_BREAK_EN
  assign brk_req = tx_break;
`else
  assign brk_req = 1'b0;
`endif

  // A break only takes hold of the line between frames.
  assign brk_hold = brk_req && (state == ST_IDLE);

  // The bit currently on the line is the last stop bit of the frame.
  assign final_stop = ((state == ST_STOP1) && !two_stop) || (state == ST_STOP2);

  // Pop a new character either from idle or exactly as the last stop bit ends,
  // which chains frames with no idle gap.
  assign load = txen && !fifo_empty && !brk_hold &&
                ((state == ST_IDLE) || (final_stop && baud_tick));

  assign fifo_re = load;
  assign busy    = (state != ST_IDLE);

  // Frame sequencer: latches the character on load and advances one bit per tick.
  always_ff @(posedge cp2 or negedge ireset) begin
    if (!ireset) begin
      // NOTE: the frame-constant registers are reset as well as the control
      // state, so nothing downstream ever sees X after reset.
      state    <= ST_IDLE;
      txd      <= 1'b1;
      txc_set  <= 1'b0;
      shreg    <= '0;
      cnt      <= '0;
      nbits    <= 4'd8;
      par_en   <= 1'b0;
      par_val  <= 1'b0;
      two_stop <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout; a later assignment in this
      // block (e.g. the shift below) overrides an earlier default cleanly.
      txc_set <= 1'b0;

      if (load) begin
        shreg    <= char_word;
        nbits    <= char_bits(ucsz);
        par_en   <= upm[1];
        par_val  <= parity_bit(char_word, char_bits(ucsz), upm[0]);
        two_stop <= usbs;
      end

      unique case (state)
        ST_IDLE: begin
          txd <= !brk_req;
          if (load) state <= ST_PEND;
        end

        ST_PEND: begin
          if (baud_tick) begin
            txd   <= 1'b0;
            state <= ST_START;
          end
        end

        ST_START: begin
          if (baud_tick) begin
            txd   <= shreg[0];
            shreg <= shreg >> 1;
            cnt   <= 4'd1;
            state <= ST_DATA;
          end
        end

        ST_DATA: begin
          if (baud_tick) begin
            if (cnt < nbits) begin
              txd   <= shreg[0];
              shreg <= shreg >> 1;
              cnt   <= cnt + 4'd1;
            end else if (par_en) begin
              txd   <= par_val;
              state <= ST_PARITY;
            end else begin
              txd   <= 1'b1;
              state <= ST_STOP1;
            end
          end
        end

        ST_PARITY: begin
          if (baud_tick) begin
            txd   <= 1'b1;
            state <= ST_STOP1;
          end
        end

        ST_STOP1, ST_STOP2: begin
          if (baud_tick) begin
            if ((state == ST_STOP1) && two_stop) begin
              txd   <= 1'b1;
              state <= ST_STOP2;
            end else if (load) begin
              txd   <= 1'b0;
              state <= ST_START;
            end else begin
              txd     <= 1'b1;
              txc_set <= 1'b1;
              state   <= ST_IDLE;
            end
          end
        end

        default: begin
          txd   <= 1'b1;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usart_tx_shifter.sv
// tb_usart_tx_shifter: directed and randomized frames against a frame-level
// reference model (expected txd bit per baud tick, expected pops and
// completion pulse position). The TX FIFO is modelled in the bench.
module tb_usart_tx_shifter;

  localparam int BAUD = 4;

  logic       cp2;
  logic       ireset;
  logic       baud_tick;
  logic       txen;
  logic [2:0] ucsz;
  logic [1:0] upm;
  logic       usbs;
  logic [8:0] fifo_dout;
  logic       fifo_empty;
  logic       fifo_re;
  logic       txd;
  logic       busy;
  logic       txc_set;
`ifdef USART_TX_BREAK_EN
  logic       tx_break;
`endif

  usart_tx_shifter #(.DATA_W(9)) dut (
    .cp2        (cp2),
    .ireset     (ireset),
    .baud_tick  (baud_tick),
    .txen       (txen),
    .ucsz       (ucsz),
    .upm        (upm),
    .usbs       (usbs),
    .fifo_dout  (fifo_dout),
    .fifo_empty (fifo_empty),
`ifdef USART_TX_BREAK_EN
    .tx_break   (tx_break),
`endif
    .fifo_re    (fifo_re),
    .txd        (txd),
    .busy       (busy),
    .txc_set    (txc_set)
  );

  initial cp2 = 1'b0;
  always #5 cp2 = ~cp2;

  int         n_checks = 0;
  int         n_pass   = 0;
  int         cyc      = 0;
  logic [8:0] fq [0:1];
  int         fcount   = 0;
  logic       last_re;
  logic       last_tick;
  logic       exp_q [$];

  task automatic check(input string tag, input logic [63:0] observed,
                       input logic [63:0] expected);
    n_checks++;
    assert (observed === expected) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
  endtask

  // Bench FIFO: combinational head word, depth 2.
  task automatic refresh();
    fifo_empty = (fcount == 0);
    fifo_dout  = (fcount > 0) ? fq[0] : 9'd0;
  endtask

  task automatic push(input logic [8:0] w);
    if (fcount < 2) begin
      fq[fcount] = w;
      fcount++;
    end
    refresh();
  endtask

  task automatic pop();
    if (fcount > 0) begin
      fq[0] = fq[1];
      fcount--;
    end
  endtask

  // One clock: capture strobes mid-cycle, then settle #1 after the edge.
  task automatic step();
    @(negedge cp2);
    last_re   = fifo_re;
    last_tick = baud_tick;
    @(posedge cp2);
    #1;
    if (last_re) pop();
    cyc++;
    baud_tick = (cyc % BAUD == 0);
    refresh();
  endtask

  // Reference frame: start, data LSB first, optional parity, stop bit(s).
  task automatic add_frame(input logic [8:0] w, input logic [2:0] uc,
                           input logic [1:0] pm, input logic sb);
    int   n;
    logic ones;
    case (uc)
      3'd0:    n = 5;
      3'd1:    n = 6;
      3'd2:    n = 7;
      3'd7:    n = 9;
      default: n = 8;
    endcase
    exp_q.push_back(1'b0);
    ones = 1'b0;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(w[i]);
      ones = ones ^ w[i];
    end
    if (pm[1]) exp_q.push_back(ones ^ pm[0]);
    exp_q.push_back(1'b1);
    if (sb) exp_q.push_back(1'b1);
  endtask

  // Record txd after each baud tick following the first pop, then compare
  // the line pattern, pop count and completion pulse position.
  task automatic run_window(input string tag, input int nrec, input int exp_txc_idx,
                            input int exp_pops, input int drop_idx, input bit scramble);
    int          idx     = 0;
    int          pops    = 0;
    int          txc_cnt = 0;
    int          txc_idx = -1;
    int          budget  = (nrec + 3) * BAUD + 8;
    bit          started = 1'b0;
    logic [63:0] obs_vec = '0;
    logic [63:0] exp_vec = '0;
    while (idx < nrec && budget > 0) begin
      step();
      if (last_re) pops++;
      if (txc_set) begin
        txc_cnt++;
        txc_idx = (started && last_tick) ? idx : -2;
      end
      if (started && last_tick) begin
        obs_vec[idx] = txd;
        idx++;
      end
      if (last_re) started = 1'b1;
      if (idx == drop_idx) txen = 1'b0;
      if (scramble && idx == 3) begin
        ucsz = 3'($urandom_range(0, 7));
        upm  = 2'($urandom_range(0, 3));
        usbs = 1'($urandom_range(0, 1));
      end
      budget--;
    end
    for (int i = 0; i < nrec; i++) exp_vec[i] = exp_q[i];
    check({tag, " ticks"}, 64'(idx), 64'(nrec));
    check({tag, " line"}, obs_vec, exp_vec);
    check({tag, " pops"}, 64'(pops), 64'(exp_pops));
    check({tag, " txc count"}, 64'(txc_cnt), (exp_txc_idx >= 0) ? 64'd1 : 64'd0);
    if (exp_txc_idx >= 0) check({tag, " txc position"}, 64'(txc_idx), 64'(exp_txc_idx));
  endtask

  task automatic frame_test(input string tag, input logic [8:0] w, input logic [2:0] uc,
                            input logic [1:0] pm, input logic sb, input bit scramble);
    int flen;
    ucsz = uc;
    upm  = pm;
    usbs = sb;
    exp_q.delete();
    add_frame(w, uc, pm, sb);
    flen = exp_q.size();
    repeat (3) exp_q.push_back(1'b1);
    push(w);
    run_window(tag, exp_q.size(), flen, 1, -1, scramble);
  endtask

  initial begin
    int   flen;
    logic idle_ok;
    ireset    = 1'b0;
    baud_tick = 1'b0;
    txen      = 1'b1;
    ucsz      = 3'b011;
    upm       = 2'b00;
    usbs      = 1'b0;
`ifdef USART_TX_BREAK_EN
    tx_break  = 1'b0;
`endif
    cyc       = $urandom_range(0, BAUD - 1);
    refresh();

    #12;
    check("reset txd", 64'(txd), 64'd1);
    check("reset busy", 64'(busy), 64'd0);
    check("reset txc_set", 64'(txc_set), 64'd0);
    check("reset fifo_re", 64'(fifo_re), 64'd0);
    #5 ireset = 1'b1;

    // Idle with empty FIFO: no pop, line held high.
    idle_ok = 1'b1;
    repeat (3 * BAUD) begin
      step();
      if (last_re || !txd || busy) idle_ok = 1'b0;
    end
    check("idle empty", 64'(idle_ok), 64'd1);

    frame_test("8N1 A5", 9'h0A5, 3'b011, 2'b00, 1'b0, 1'b0);
    frame_test("7E2 41", 9'h041, 3'b010, 2'b10, 1'b1, 1'b0);
    frame_test("9O1 1FF", 9'h1FF, 3'b111, 2'b11, 1'b0, 1'b0);
    frame_test("9O1 100", 9'h100, 3'b111, 2'b11, 1'b0, 1'b0);
    frame_test("5N1 upper ignored", 9'h1E6, 3'b000, 2'b01, 1'b0, 1'b0);

    // Back-to-back: two words queued, no idle gap between frames.
    ucsz = 3'b011; upm = 2'b00; usbs = 1'b0;
    exp_q.delete();
    add_frame(9'h055, 3'b011, 2'b00, 1'b0);
    add_frame(9'h0AA, 3'b011, 2'b00, 1'b0);
    flen = exp_q.size();
    repeat (3) exp_q.push_back(1'b1);
    push(9'h055);
    push(9'h0AA);
    run_window("b2b", exp_q.size(), flen, 2, -1, 1'b0);
    check("b2b fifo empty", 64'(fcount), 64'd0);

    // txen dropped at data bit 3: frame finishes, queued word stays put.
    exp_q.delete();
    add_frame(9'h033, 3'b011, 2'b00, 1'b0);
    flen = exp_q.size();
    repeat (4) exp_q.push_back(1'b1);
    push(9'h033);
    push(9'h0F0);
    run_window("txen drop", exp_q.size(), flen, 1, 4, 1'b0);
    check("txen drop fifo left", 64'(fcount), 64'd1);
    fcount = 0;
    refresh();
    txen = 1'b1;

    // Async reset during data bit 4 aborts the frame at once.
    exp_q.delete();
    add_frame(9'h0C6, 3'b011, 2'b00, 1'b0);
    push(9'h0C6);
    run_window("pre-reset", 6, -1, 1, -1, 1'b0);
    #3 ireset = 1'b0;
    #1;
    check("mid reset txd", 64'(txd), 64'd1);
    check("mid reset busy", 64'(busy), 64'd0);
    repeat (2) step();
    #3 ireset = 1'b1;
    frame_test("post-reset 8N1 3C", 9'h03C, 3'b011, 2'b00, 1'b0, 1'b0);

`ifdef USART_TX_BREAK_EN
    // Break while idle: line low, no pop until release.
    tx_break = 1'b1;
    push(9'h05A);
    idle_ok = 1'b1;
    repeat (2 * BAUD) begin
      step();
      if (last_re) idle_ok = 1'b0;
    end
    check("break txd", 64'(txd), 64'd0);
    check("break no pop", 64'(idle_ok), 64'd1);
    check("break fifo held", 64'(fcount), 64'd1);
    tx_break = 1'b0;
    exp_q.delete();
    add_frame(9'h05A, 3'b011, 2'b00, 1'b0);
    flen = exp_q.size();
    repeat (3) exp_q.push_back(1'b1);
    run_window("after break", exp_q.size(), flen, 1, -1, 1'b0);
`endif

    // Random characters and formats; configuration scrambled mid-frame.
    for (int k = 0; k < 10; k++) begin
      frame_test($sformatf("rand %0d", k), 9'($urandom_range(0, 511)),
                 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/usart_tx_shifter.md
Name: usart_tx_shifter

Overview:
- USART transmit serializer. Sits directly downstream of the TX FIFO (the UDR buffer, combinational-output mode, DEPTH 2) and drives the TXD pin.
- Pops one character per frame and emits start, 5–9 data bits LSB first, optional parity, and 1–2 stop bits, one bit per baud_tick.
- Pulses txc_set when the line goes idle, which sets TXCn in UCSRnA.

Parameters:
- DATA_W, 9, width of the FIFO data word (bit 8 = TXB8).

Ports:
- cp2, input, 1, system clock.
- ireset, input, 1, reset: asynchronous, active-low.
- baud_tick, input, 1, one-cycle pulse per bit period from the baud generator.
- txen, input, 1, TXENn.
- ucsz, input, 3, character size: 000=5, 001=6, 010=7, 011=8, 111=9 bits; other codes give 8 bits.
- upm, input, 2, parity mode: 00 or 01 = none, 10 = even, 11 = odd.
- usbs, input, 1, stop bits: 0 = one stop bit, 1 = two stop bits.
- fifo_dout, input, DATA_W, FIFO head word.
- fifo_empty, input, 1, FIFO empty flag.
- fifo_re, output, 1, FIFO pop strobe (combinational).
- txd, output, 1, serial line (registered).
- busy, output, 1, a frame is pending or in progress.
- txc_set, output, 1, one-cycle pulse: transmission complete.

Behaviour:
- Reset values: txd=1, busy=0, txc_set=0, fifo_re=0, state IDLE. Async reset mid-frame aborts the frame immediately; txd returns to 1 and the FIFO is untouched.
- States: IDLE, PEND, START, DATA, PARITY, STOP1, STOP2. txd, state and bit counter change only on cycles with baud_tick=1, except IDLE→PEND.
- load = txen && !fifo_empty && (state==IDLE || (final stop bit && baud_tick)).
- fifo_re = load.
- On load, in the same edge, latch: fifo_dout into shreg; nbits from ucsz; par_en/odd from upm; usbs. These are frame-constant; config changes mid-frame are ignored.
- Parity bit = XOR of the nbits data bits, inverted for odd parity. It is computed at load.
- Transitions on baud_tick:
  - IDLE→PEND on load (no tick needed).
  - PEND→START: txd←0.
  - START→DATA: txd←shreg[0], cnt←1.
  - DATA, cnt<nbits: txd←shreg[cnt], cnt++.
  - DATA, cnt==nbits: if par_en, txd←parity and go to PARITY; else txd←1 and go to STOP1.
  - PARITY→STOP1: txd←1.
  - STOP1: if usbs, go to STOP2 with txd=1; otherwise this is the final stop bit.
  - STOP2: final stop bit.
- At the tick that ends the final stop bit:
  - If load: back-to-back frame with no idle gap. txd←0, state START, no txc_set.
  - Otherwise: state IDLE, txd=1, txc_set=1 for one cycle.
- busy = (state != IDLE).
- Latency: first start bit begins at the first baud_tick after load, at most one bit period.
- txen deasserted mid-frame: the current frame completes, no further loads occur, and txc_set fires at its end. Words remaining in the FIFO are not consumed.
- fifo_empty while idle: no pop, txd held 1.
- 9-bit mode: data bit 8 = fifo_dout[8]. For sizes below 9 bits, upper bits are ignored.

Optional Feature:
- Macro USART_TX_BREAK_EN.
- When defined: extra input tx_break (1 bit).
  - While tx_break=1 and state==IDLE, txd is forced to 0 (registered, next cycle) and load is inhibited.
  - Raising tx_break mid-frame has no effect until the frame ends.
  - On release, txd returns to 1 the next cycle.
- When undefined: the port is absent and there is no break capability.

Decomposition:
- Package usart_pkg holds:
  - tx_state_t enum;
  - UCSZ_* and UPM_* localparams;
  - function char_bits(ucsz) returning 5..9;
  - function parity_bit(data, nbits, odd).
- No sub-module: a single flat module.

Test Plan:
- 8N1 (ucsz=011, upm=00, usbs=0), push 0xA5 → txd per tick 0,1,0,1,0,0,1,0,1,1. txc_set pulses once after the stop bit; fifo_re pulses exactly once.
- 7E2 (ucsz=010, upm=10, usbs=1), push 0x41 → 0,1,0,0,0,0,0,1, parity 0, then 1,1.
- 9O1 (ucsz=111, upm=11), push 0x1FF → start, nine 1s, parity 0, stop 1. Then push 0x100 → start, 0×8, 1, parity 0, stop.
- Back-to-back: push 0x55 and 0xAA with FIFO full → second start bit immediately follows first stop bit. txc_set only after the second frame; FIFO ends empty.
- Drop txen at data bit 3 of 0x33 with a second word queued → frame completes, txc_set fires, second word stays in FIFO, txd stays 1.
- Assert ireset low during data bit 4 → txd=1 and busy=0 immediately; after release, a new push transmits correctly. With USART_TX_BREAK_EN: tx_break=1 in IDLE → txd=0, no pop until release.
